// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scanned driver for an 8x8 LED matrix.
// Frames arrive through a valid/ready handshake into a shadow buffer and are
// promoted to the active buffer only at a scan-frame boundary, so a frame is
// never shown half-old/half-new. Each row dwells DWELL_CYCLES clocks, with the
// first GUARD_CYCLES of every row dark to hide ghosting from the row switch.
// The overlay layer blinks with a half-period of BLINK_FRAMES scan frames.
module led_matrix_scanner #(
   parameter int DWELL_CYCLES = 1000,
   parameter int GUARD_CYCLES = 2,
   parameter int BLINK_FRAMES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0][7:0] frame_in,
   input  logic [7:0][7:0] overlay_in,
   input  logic            frame_valid,
   output logic            frame_ready,
   input  logic            blank,
   output logic [7:0]      row_sel,
   output logic [7:0]      col_data,
   output logic [2:0]      row_idx,
   output logic            frame_done
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [DW-1:0] GUARD_LEN  = DW'(GUARD_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic [2:0]      row_cnt_q, row_cnt_d;
   logic [7:0][7:0] active_q, active_d;
   logic [7:0][7:0] active_ovl_q, active_ovl_d;
   logic [7:0][7:0] shadow_q, shadow_d;
   logic [7:0][7:0] shadow_ovl_q, shadow_ovl_d;
   logic            pending_q, pending_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_on_q, blink_on_d;
   logic [7:0]      row_sel_q, row_sel_d;
   logic [7:0]      col_data_q, col_data_d;
   logic [2:0]      row_idx_q, row_idx_d;
   logic            frame_done_q, frame_done_d;
   logic            frame_ready_q, frame_ready_d;

   logic            boundary;
   logic            accept;
   logic            swap;
   logic [7:0]      row_pixels;

   // Frame boundary decode and handshake events.
   always_comb begin
      boundary = (row_cnt_q == 3'd7) && (dwell_cnt_q == DWELL_LAST);
      accept   = frame_valid && frame_ready_q;
      swap     = boundary && pending_q;
   end

   // Dwell and row counters; row wrap 7 -> 0 closes a scan frame.
   always_comb begin
      dwell_cnt_d = dwell_cnt_q + 1'b1;
      row_cnt_d   = row_cnt_q;
      if (dwell_cnt_q == DWELL_LAST) begin
         dwell_cnt_d = '0;
         row_cnt_d   = row_cnt_q + 3'd1;
      end
      // Decoding the next state lets frame_done be a flop that is high
      // exactly during the boundary cycle.
      frame_done_d = (row_cnt_d == 3'd7) && (dwell_cnt_d == DWELL_LAST);
   end

   // Shadow capture on accept, promotion to active on the boundary.
   // Accept and swap are mutually exclusive because ready == ~pending.
   always_comb begin
      shadow_d     = shadow_q;
      shadow_ovl_d = shadow_ovl_q;
      active_d     = active_q;
      active_ovl_d = active_ovl_q;
      pending_d    = pending_q;
      if (accept) begin
         shadow_d     = frame_in;
         shadow_ovl_d = overlay_in;
         pending_d    = 1'b1;
      end
      if (swap) begin
         active_d     = shadow_q;
         active_ovl_d = shadow_ovl_q;
         pending_d    = 1'b0;
      end
      frame_ready_d = ~pending_d;
   end

   // Overlay blink phase, advanced once per completed scan frame.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (boundary) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Registered row/column drive for the current counter position.
   always_comb begin
      row_pixels = active_q[row_cnt_q] | (blink_on_q ? active_ovl_q[row_cnt_q] : 8'h00);
      row_idx_d  = row_cnt_q;
      row_sel_d  = 8'b1 << row_cnt_q;
      col_data_d = (dwell_cnt_q < GUARD_LEN) ? 8'h00 : row_pixels;
      if (blank) begin
         row_sel_d  = 8'h00;
         col_data_d = 8'h00;
      end
   end

   // State update with synchronous reset of all control and buffers.
   always_ff @(posedge clk) begin
      if (reset) begin
         dwell_cnt_q   <= '0;
         row_cnt_q     <= '0;
         active_q      <= '0;
         active_ovl_q  <= '0;
         shadow_q      <= '0;
         shadow_ovl_q  <= '0;
         pending_q     <= 1'b0;
         blink_cnt_q   <= '0;
         blink_on_q    <= 1'b1;
         row_sel_q     <= '0;
         col_data_q    <= '0;
         row_idx_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_ready_q <= 1'b0;
      end else begin
         dwell_cnt_q   <= dwell_cnt_d;
         row_cnt_q     <= row_cnt_d;
         active_q      <= active_d;
         active_ovl_q  <= active_ovl_d;
         shadow_q      <= shadow_d;
         shadow_ovl_q  <= shadow_ovl_d;
         pending_q     <= pending_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_on_q    <= blink_on_d;
         row_sel_q     <= row_sel_d;
         col_data_q    <= col_data_d;
         row_idx_q     <= row_idx_d;
         frame_done_q  <= frame_done_d;
         frame_ready_q <= frame_ready_d;
      end
   end

   assign row_sel     = row_sel_q;
   assign col_data    = col_data_q;
   assign row_idx     = row_idx_q;
   assign frame_done  = frame_done_q;
   assign frame_ready = frame_ready_q;

endmodule
